// File: rtl/denise_pkg.sv
// Shared types and constants for the Denise bitplane serializer.
// The shres path is only built when DENISE_SHRES_EN is defined.
package denise_pkg;

    localparam int unsigned DEF_NPLANES   = 8;
    localparam int unsigned DEF_DLY_DEPTH = 64;

    typedef enum logic [1:0] {
        RES_LORES,
        RES_HIRES,
        RES_SHRES
    } resolution_e;

    // Clock ticks per pixel at each resolution.
    localparam int unsigned TICKS_LORES = 4;
    localparam int unsigned TICKS_HIRES = 2;
    localparam int unsigned TICKS_SHRES = 1;

    function automatic logic [5:0] scroll_ticks(input resolution_e res, input logic [3:0] scroll);
        logic [5:0] w_s;
        w_s = {2'b00, scroll};
        case (res)
            RES_HIRES: return 6'(w_s * TICKS_HIRES);
            RES_SHRES: return 6'(w_s * TICKS_SHRES);
            default:   return 6'(w_s * TICKS_LORES);
        endcase
    endfunction

endpackage

// File: rtl/denise_pixel_delay.sv
// Circular-buffer pixel delay with fill guard, zero-delay bypass and registered output.
module denise_pixel_delay #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic [AW-1:0]    i_delay,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_fill;
    logic [AW-1:0]    w_rd_ptr;

    assign w_rd_ptr = r_wr_ptr - i_delay;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Slots not yet written since reset read as zero rather than stale RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            o_data   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_fill != AW'(DEPTH - 1)) begin
                r_fill <= r_fill + 1'b1;
            end
            if (i_delay == '0) begin
                o_data <= i_data;
            end else if (i_delay > r_fill) begin
                o_data <= '0;
            end else begin
                o_data <= r_mem[w_rd_ptr];
            end
        end
    end

endmodule

// File: rtl/denise_bitplane_serializer.sv
// Bitplane holding registers, shifters and scroll delay producing the colour select stream.
// Optional super-hires support is enabled by defining DENISE_SHRES_EN.
module denise_bitplane_serializer
    import denise_pkg::*;
#(
    parameter int unsigned NPLANES   = DEF_NPLANES,
    parameter int unsigned DLY_DEPTH = DEF_DLY_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk7_en,
    input  logic               wr_en,
    input  logic [2:0]         wr_plane,
    input  logic [15:0]        wr_data,
    input  logic               hires,
    input  logic               shres,
    input  logic [3:0]         nplanes,
    input  logic [3:0]         scroll,
    output logic [NPLANES-1:0] select
);

    localparam int unsigned AW = $clog2(DLY_DEPTH);

    logic [15:0]        r_hold [NPLANES];
    logic [15:0]        r_sh   [NPLANES];
    logic               r_load_pend;
    logic [1:0]         r_phase;
    resolution_e        w_res;
    logic               w_shift_en;
    logic               w_wr_plane0;
    logic               w_load;
    logic [NPLANES-1:0] w_pix;
    logic [AW-1:0]      w_delay;

`ifdef DENISE_SHRES_EN
    assign w_res = shres ? RES_SHRES : (hires ? RES_HIRES : RES_LORES);
`else
    logic w_unused_shres;
    assign w_unused_shres = shres;
    assign w_res = hires ? RES_HIRES : RES_LORES;
`endif

    always_comb begin
        w_shift_en = clk7_en;
        case (w_res)
            RES_HIRES: w_shift_en = clk7_en | (r_phase == 2'd2);
`ifdef DENISE_SHRES_EN
            RES_SHRES: w_shift_en = 1'b1;
`endif
            default:   w_shift_en = clk7_en;
        endcase
    end

    assign w_wr_plane0 = clk7_en & wr_en & (wr_plane == 3'd0);
    assign w_load      = clk7_en & r_load_pend;
    assign w_delay     = AW'(scroll_ticks(w_res, scroll));

    // A plane-0 write in the load cycle re-arms the pending load; the load itself takes the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned n = 0; n < NPLANES; n++) begin
                r_hold[n] <= '0;
                r_sh[n]   <= '0;
            end
            r_load_pend <= 1'b0;
            r_phase     <= 2'd0;
        end else begin
            r_phase <= clk7_en ? 2'd1 : r_phase + 2'd1;
            for (int unsigned n = 0; n < NPLANES; n++) begin
                if (clk7_en && wr_en && (wr_plane == 3'(n))) begin
                    r_hold[n] <= wr_data;
                end
                if (w_load) begin
                    r_sh[n] <= r_hold[n];
                end else if (w_shift_en) begin
                    r_sh[n] <= {r_sh[n][14:0], 1'b0};
                end
            end
            if (w_wr_plane0) begin
                r_load_pend <= 1'b1;
            end else if (w_load) begin
                r_load_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_pix = '0;
        for (int unsigned n = 0; n < NPLANES; n++) begin
            if (n < 32'(nplanes)) begin
                w_pix[n] = r_sh[n][15];
            end
        end
    end

    denise_pixel_delay #(
        .WIDTH (NPLANES),
        .DEPTH (DLY_DEPTH)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .i_data  (w_pix),
        .i_delay (w_delay),
        .o_data  (select)
    );

endmodule

// File: doc/denise_bitplane_serializer.md
Name: denise_bitplane_serializer

Overview:
- Upstream neighbour of the HAM/colour-lookup stage in Denise: turns per-plane 16-bit bitplane data words into the 8-bit per-pixel colour select stream, one select value per 28 MHz clk.
- Handles lores/hires/shres shift rates, the playfield scroll delay and the enabled-plane count.
- Output select is fed straight into the colour lookup / HAM select input.

Parameters:
- NPLANES, 8, number of bitplane shifters and width of select.
- DLY_DEPTH, 64, depth in clk ticks of the scroll delay line; power of two, at least 61.

Ports:
- clk  in  1  28 MHz clock.
- reset  in  1  synchronous, active-high reset.
- clk7_en  in  1  7 MHz clock enable, high one clk in four.
- wr_en  in  1  bitplane data write strobe; sampled only when clk7_en=1.
- wr_plane  in  3  plane index 0..7 for the write.
- wr_data  in  16  bitplane data word.
- hires  in  1  hires mode: shift every 2 clk.
- shres  in  1  super-hires mode: shift every clk; overrides hires.
- nplanes  in  4  enabled plane count 0..8; values above 8 behave as 8.
- scroll  in  4  scroll delay in current-resolution pixels, 0..15.
- select  out  8  colour select, bit n = plane n pixel.

Behaviour:
- Holding regs hold[0..7]: on clk7_en & wr_en, hold[wr_plane] <= wr_data. A write to plane 0 sets load_pend.
- Load: on the next clk7_en cycle after load_pend is set (never the same cycle as the plane-0 write), every shifter sh[n] <= hold[n] and load_pend clears.
  - If that load cycle also carries a new plane-0 write, the load uses the old hold[0] and load_pend is set again.
- Phase: 2-bit counter. clk7_en forces next phase=1, otherwise it increments; reset=0.
- Shift enable:
  - lores: clk7_en.
  - hires: clk7_en or phase==2.
  - shres: every clk.
- Shifting moves left, inserting 0 at bit 0. Load takes priority over shift in the same cycle.
- Raw pixel: pix[n] = sh[n][15] if n < min(nplanes,8), else 0.
- Delay: d = scroll*4 (lores), scroll*2 (hires), scroll (shres), giving a range of 0..60.
- Output timing: select(t+1) = pix(t-d). The delay line is a circular buffer written every clk, read at wr_ptr-d with a registered output. With d=0 the buffer is bypassed and select(t+1) = pix(t).
- Fill counter saturates at DLY_DEPTH-1. If d > fill, select takes 0 (no stale RAM data after reset).
- Changes to scroll, hires or shres take effect on the next clk. Pixel drop or repeat at the switch is acceptable; no glitch beyond one clk.
- nplanes change takes effect on the next pix sample; already-delayed pixels are unaffected.
- Reset (takes effect at any point, including mid-line):
  - hold, sh, load_pend, phase, wr_ptr, fill and select all go to 0.
  - clk7_en and wr_en during reset are ignored.

Optional Feature:
- DENISE_SHRES_EN
  - Defined: shres mode works as described.
  - Undefined: the shres input is ignored and treated as 0 (hires/lores only). The d range becomes 0..60 with no scroll*1 path, and the shres shift-enable logic is not built.

Decomposition:
- Package denise_pkg holds:
  - NPLANES and DLY_DEPTH defaults.
  - resolution enum {RES_LORES, RES_HIRES, RES_SHRES}.
  - scroll-to-tick multiplier constants.
- One sub-module, denise_pixel_delay: circular buffer with wr_ptr, fill counter, d=0 bypass and registered output, parameterised by width and depth.

Test Plan:
- Lores, nplanes=1, scroll=0: write plane0=16'h8001 at clk7_en cycle T; load at the next clk7_en (T+4) -> select=8'h01 for 4 clk starting T+5, 0 for 56 clk, 8'h01 for 4 clk.
- Hires, nplanes=8, all planes written 16'hFFFF, plane0 written last -> select=8'hFF for 32 clk after load+1. With nplanes=3 -> 8'h07.
- Lores, scroll=5, same data as scenario 1 -> first 8'h01 appears exactly 20 clk later than with scroll=0.
- Reset asserted for 1 clk mid-line, then scroll=15 lores -> select=0 for the first 60 clk after reset (fill guard), even though the RAM holds old data.
- Plane-0 write coincident with a pending load cycle (new data 16'h0000, previous 16'hFFFF) -> shifter loads 16'hFFFF, a second load of 16'h0000 follows 4 clk later.
- With DENISE_SHRES_EN, shres=1, plane0=16'hAAAA -> select alternates 01/00 every clk for 16 clk. Without the macro, the same stimulus -> alternates every 2 clk.
